// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : imm_gen_pipe                                                 |
// | Description : Registered immediate generator for the decode stage. Takes   |
// |               a 32-bit instruction on a valid/ready input, extracts and    |
// |               extends its immediate to XLEN bits (I/S/B/U/J/Z formats)     |
// |               and delivers it through a two-entry skid buffer. Provides    |
// |               flush, an illegal-format flag and a saturating counter of    |
// |               accepted illegal entries.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module imm_gen_pipe #(
   parameter int XLEN       = 32,    // 32 or 64
   parameter bit OPC_DECODE = 1'b1,  // 1: format from opcode, 0: from imm_src
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [2:0]       imm_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [2:0]       imm_fmt,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [2:0] c_fmt_i   = 3'b000;
   localparam logic [2:0] c_fmt_s   = 3'b001;
   localparam logic [2:0] c_fmt_b   = 3'b010;
   localparam logic [2:0] c_fmt_u   = 3'b011;
   localparam logic [2:0] c_fmt_j   = 3'b100;
   localparam logic [2:0] c_fmt_z   = 3'b101;
   localparam logic [2:0] c_fmt_bad = 3'b111;

   localparam logic [6:0] c_op_imm    = 7'b0010011;
   localparam logic [6:0] c_op_load   = 7'b0000011;
   localparam logic [6:0] c_op_jalr   = 7'b1100111;
   localparam logic [6:0] c_op_store  = 7'b0100011;
   localparam logic [6:0] c_op_branch = 7'b1100011;
   localparam logic [6:0] c_op_lui    = 7'b0110111;
   localparam logic [6:0] c_op_auipc  = 7'b0010111;
   localparam logic [6:0] c_op_jal    = 7'b1101111;
   localparam logic [6:0] c_op_system = 7'b1110011;

   localparam logic [CNT_W-1:0] c_cnt_max = '1;
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   logic [2:0]       w_dec_fmt;
   logic [2:0]       w_fmt;
   logic             w_illegal;
   logic [XLEN-1:0]  w_imm;
   logic             w_in_xfer;
   logic             w_out_xfer;

   // Main entry drives the outputs; skid entry absorbs one input during a stall.
   logic             r_main_valid;
   logic [XLEN-1:0]  r_main_imm;
   logic [2:0]       r_main_fmt;
   logic             r_main_illegal;
   logic             r_skid_valid;
   logic [XLEN-1:0]  r_skid_imm;
   logic [2:0]       r_skid_fmt;
   logic             r_skid_illegal;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_illegal_cnt;

   // Format decode from the opcode; SYSTEM splits on funct3[2] (CSR immediate forms).
   always_comb begin
      w_dec_fmt = c_fmt_bad;
      case (instr[6:0])
         c_op_imm, c_op_load, c_op_jalr: w_dec_fmt = c_fmt_i;
         c_op_store:                     w_dec_fmt = c_fmt_s;
         c_op_branch:                    w_dec_fmt = c_fmt_b;
         c_op_lui, c_op_auipc:           w_dec_fmt = c_fmt_u;
         c_op_jal:                       w_dec_fmt = c_fmt_j;
         c_op_system:                    w_dec_fmt = instr[14] ? c_fmt_z : c_fmt_i;
         default:                        w_dec_fmt = c_fmt_bad;
      endcase
   end

   assign w_fmt     = OPC_DECODE ? w_dec_fmt : imm_src;
   assign w_illegal = w_fmt[2] & w_fmt[1];

   // Immediate build: start from a full sign fill, then overwrite the low bits.
   always_comb begin
      w_imm = {XLEN{instr[31]}};
      case (w_fmt)
         c_fmt_i: w_imm[11:0] = instr[31:20];
         c_fmt_s: w_imm[11:0] = {instr[31:25], instr[11:7]};
         c_fmt_b: w_imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         c_fmt_u: w_imm[31:0] = {instr[31:12], 12'b0};
         c_fmt_j: w_imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         c_fmt_z: begin
            w_imm      = '0;
            w_imm[4:0] = instr[19:15];
         end
         default: w_imm = '0;
      endcase
   end

   // Flush takes priority, so an input in the flush cycle is never accepted.
   assign w_in_xfer  = in_valid & r_in_ready & ~flush;
   assign w_out_xfer = r_main_valid & out_ready;

   // Skid buffer control; in_ready is registered as the complement of next skid occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid   <= 1'b0;
         r_main_imm     <= '0;
         r_main_fmt     <= 3'b000;
         r_main_illegal <= 1'b0;
         r_skid_valid   <= 1'b0;
         r_skid_imm     <= '0;
         r_skid_fmt     <= 3'b000;
         r_skid_illegal <= 1'b0;
         r_in_ready     <= 1'b1;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (r_skid_valid) begin
         // Input is blocked while skid holds; only a drain changes state.
         if (w_out_xfer) begin
            r_main_imm     <= r_skid_imm;
            r_main_fmt     <= r_skid_fmt;
            r_main_illegal <= r_skid_illegal;
            r_skid_valid   <= 1'b0;
            r_in_ready     <= 1'b1;
         end
      end else if (w_in_xfer) begin
         if (!r_main_valid || w_out_xfer) begin
            r_main_valid   <= 1'b1;
            r_main_imm     <= w_imm;
            r_main_fmt     <= w_fmt;
            r_main_illegal <= w_illegal;
         end else begin
            r_skid_valid   <= 1'b1;
            r_skid_imm     <= w_imm;
            r_skid_fmt     <= w_fmt;
            r_skid_illegal <= w_illegal;
            r_in_ready     <= 1'b0;
         end
      end else if (w_out_xfer) begin
         r_main_valid <= 1'b0;
      end
   end

   // Saturating count of accepted illegal entries; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_cnt <= '0;
      end else if (w_in_xfer && w_illegal && (r_illegal_cnt != c_cnt_max)) begin
         r_illegal_cnt <= r_illegal_cnt + c_cnt_one;
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_main_valid;
   assign imm         = r_main_imm;
   assign imm_fmt     = r_main_fmt;
   assign illegal     = r_main_illegal;
   assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire
